// File: rtl/x3mult_bist_ctrl_pkg.sv
// Shared definitions for the x3mult BIST controller: FSM states, pattern
// generator taps, MISR defaults and the pattern-step helper.
package bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_INIT = 3'd1,
      ST_RUN  = 3'd2,
      ST_COMP = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   localparam int          CNT_W         = 8;
   localparam logic [2:0]  LFSR_TAP      = 3'b110;
   localparam logic [7:0]  DEF_MISR_POLY = 8'h1D;
   localparam logic [7:0]  DEF_MISR_SEED = 8'h00;

   // Shift left with feedback from the tapped bits; 000 is never reached from a nonzero seed.
   function automatic logic [2:0] lfsr_next(input logic [2:0] p);
      return {p[1:0], ^(p & LFSR_TAP)};
   endfunction

endpackage

// File: rtl/x3mult_bist_ctrl_misr.sv
// Galois multiple-input signature register compacting the CUT response.
module bist_misr #(
   parameter int               SIG_W = 8,
   parameter logic [SIG_W-1:0] POLY  = 8'h1D,
   parameter logic [SIG_W-1:0] SEED  = 8'h00,
   parameter int               IN_W  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [IN_W-1:0]  data_i,
   output logic [SIG_W-1:0] sig_o
);

   logic [SIG_W-1:0] sig_q;
   logic [SIG_W-1:0] sig_d;

   function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] m,
                                                  input logic [IN_W-1:0]  d);
      logic [SIG_W-1:0] fb;
      fb = m[SIG_W-1] ? POLY : {SIG_W{1'b0}};
      return {m[SIG_W-2:0], 1'b0} ^ fb ^ {{(SIG_W-IN_W){1'b0}}, d};
   endfunction

   // Next signature: clear beats load beats shift.
   always_comb begin
      sig_d = sig_q;
      if (clr_i) begin
         sig_d = {SIG_W{1'b0}};
      end else if (load_i) begin
         sig_d = SEED;
      end else if (shift_i) begin
         sig_d = misr_step(sig_q, data_i);
      end else begin
         sig_d = sig_q;
      end
   end

   // Signature register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= {SIG_W{1'b0}};
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig_o = sig_q;

endmodule

// File: rtl/x3mult_bist_ctrl.sv
// BIST controller for the x3mult CUT: pattern generation, run sequencing,
// signature compaction and golden-signature compare.
module x3mult_bist_ctrl
   import bist_pkg::*;
#(
   parameter int               NPAT      = 8,
   parameter logic [2:0]       SEED      = 3'b001,
   parameter int               SIG_W     = 8,
   parameter logic [SIG_W-1:0] MISR_POLY = SIG_W'(DEF_MISR_POLY),
   parameter logic [SIG_W-1:0] MISR_SEED = SIG_W'(DEF_MISR_SEED)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             mode,
   input  logic [SIG_W-1:0] golden_sig,
   input  logic [2:0]       cut_out,
   output logic [2:0]       cut_in,
   output logic             test_mode,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] signature
);

   localparam logic [2:0]       SEED_EFF = (SEED == 3'b000) ? 3'b001 : SEED;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NPAT - 1);

   state_e           state_q, state_d;
   logic [2:0]       cut_in_q, cut_in_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mode_q, mode_d;
   logic             pass_q, pass_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             misr_clr_s, misr_load_s, misr_shift_s;
   logic [SIG_W-1:0] sig_s;

   // Next-state and datapath control; abort overrides every state.
   always_comb begin
      state_d      = state_q;
      cut_in_d     = cut_in_q;
      cnt_d        = cnt_q;
      mode_d       = mode_q;
      pass_d       = pass_q;
      misr_clr_s   = 1'b0;
      misr_load_s  = 1'b0;
      misr_shift_s = 1'b0;
      if (abort) begin
         state_d    = ST_IDLE;
         cut_in_d   = 3'b000;
         cnt_d      = {CNT_W{1'b0}};
         mode_d     = 1'b0;
         pass_d     = 1'b0;
         misr_clr_s = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) state_d = ST_INIT;
               else       state_d = ST_IDLE;
            end
            ST_INIT: begin
               mode_d      = mode;
               cut_in_d    = mode ? 3'b000 : SEED_EFF;
               cnt_d       = {CNT_W{1'b0}};
               misr_load_s = 1'b1;
               state_d     = ST_RUN;
            end
            ST_RUN: begin
               misr_shift_s = 1'b1;
               cut_in_d     = mode_q ? (cut_in_q + 3'd1) : lfsr_next(cut_in_q);
               cnt_d        = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
               if (cnt_q == LAST_CNT) state_d = ST_COMP;
               else                   state_d = ST_RUN;
            end
            ST_COMP: begin
               pass_d  = (sig_s == golden_sig);
               state_d = ST_DONE;
            end
            ST_DONE: begin
               if (start) begin
                  state_d = ST_INIT;
                  pass_d  = 1'b0;
               end else begin
                  state_d = ST_DONE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      busy_d = (state_d == ST_INIT) || (state_d == ST_RUN) || (state_d == ST_COMP);
      done_d = (state_d == ST_DONE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cut_in_q <= 3'b000;
         cnt_q    <= {CNT_W{1'b0}};
         mode_q   <= 1'b0;
         pass_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cut_in_q <= cut_in_d;
         cnt_q    <= cnt_d;
         mode_q   <= mode_d;
         pass_q   <= pass_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   bist_misr #(
      .SIG_W (SIG_W),
      .POLY  (MISR_POLY),
      .SEED  (MISR_SEED),
      .IN_W  (3)
   ) u_misr (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (misr_clr_s),
      .load_i  (misr_load_s),
      .shift_i (misr_shift_s),
      .data_i  (cut_out),
      .sig_o   (sig_s)
   );

   assign cut_in    = cut_in_q;
   assign busy      = busy_q;
   assign test_mode = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign signature = sig_s;

endmodule

// File: tb/tb_x3mult_bist_ctrl.sv
// Directed bench for x3mult_bist_ctrl: two instances (NPAT=8/SEED=001 and
// NPAT=3/SEED=000) checked every cycle against a run-level model.
module tb_x3mult_bist_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, start, abort, mode;
   logic [7:0] golden;
   int         sel;

   logic [2:0] cut_in_w  [2];
   logic [2:0] cut_out_w [2];
   logic       tmode_w [2], busy_w [2], done_w [2], pass_w [2];
   logic [7:0] sig_w [2];

   int n_chk  = 0;
   int n_fail = 0;

   logic [2:0] lfsr_tab [7] = '{3'd1, 3'd2, 3'd5, 3'd3, 3'd7, 3'd6, 3'd4};

   always #5 clk = ~clk;

   // CUT stand-in: 0 = tied low, 1 = tied 001, otherwise 3*x mod 8
   function automatic logic [2:0] cut_fn(input int s, input logic [2:0] p);
      logic [4:0] x;
      x = {2'b00, p} * 5'd3;
      if (s == 0)      return 3'b000;
      else if (s == 1) return 3'b001;
      else             return x[2:0];
   endfunction

   assign cut_out_w[0] = cut_fn(sel, cut_in_w[0]);
   assign cut_out_w[1] = cut_fn(sel, cut_in_w[1]);

   x3mult_bist_ctrl #(.NPAT(8), .SEED(3'b001)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
      .golden_sig(golden), .cut_out(cut_out_w[0]), .cut_in(cut_in_w[0]),
      .test_mode(tmode_w[0]), .busy(busy_w[0]), .done(done_w[0]),
      .pass(pass_w[0]), .signature(sig_w[0]));

   x3mult_bist_ctrl #(.NPAT(3), .SEED(3'b000)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
      .golden_sig(golden), .cut_out(cut_out_w[1]), .cut_in(cut_in_w[1]),
      .test_mode(tmode_w[1]), .busy(busy_w[1]), .done(done_w[1]),
      .pass(pass_w[1]), .signature(sig_w[1]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- run-level model ----------------
   int         m_t   [2] = '{-1, -1};
   int         m_np  [2] = '{8, 3};
   logic [2:0] m_cut [2] = '{3'd0, 3'd0};
   logic [7:0] m_sig [2] = '{8'd0, 8'd0};
   logic       m_md  [2] = '{1'b0, 1'b0};
   logic       m_busy[2] = '{1'b0, 1'b0};
   logic       m_done[2] = '{1'b0, 1'b0};
   logic       m_pass[2] = '{1'b0, 1'b0};

   function automatic logic [2:0] pat(input logic md, input int k);
      if (md) return 3'(k % 8);
      else    return lfsr_tab[k % 7];
   endfunction

   function automatic logic [7:0] misr(input logic [7:0] s, input logic [2:0] d);
      logic [7:0] r;
      r = (s << 1) ^ {5'd0, d};
      if (s[7]) r = r ^ 8'h1D;
      return r;
   endfunction

   task automatic model_clear(input int d);
      m_t[d] = -1; m_cut[d] = 3'd0; m_sig[d] = 8'd0; m_md[d] = 1'b0;
      m_busy[d] = 1'b0; m_done[d] = 1'b0; m_pass[d] = 1'b0;
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      for (int d = 0; d < 2; d++) begin
         if (!rst_n || abort) begin
            model_clear(d);
         end else if (m_t[d] < 0) begin
            if (start) begin
               m_t[d] = 0; m_busy[d] = 1'b1; m_done[d] = 1'b0; m_pass[d] = 1'b0;
            end
         end else begin
            m_t[d]++;
            if (m_t[d] == 1) begin
               m_md[d]  = mode;
               m_cut[d] = pat(mode, 0);
               m_sig[d] = 8'h00;
            end else if (m_t[d] <= m_np[d] + 1) begin
               m_sig[d] = misr(m_sig[d], cut_fn(sel, m_cut[d]));
               m_cut[d] = pat(m_md[d], m_t[d] - 1);
            end else begin
               m_pass[d] = (m_sig[d] == golden);
               m_busy[d] = 1'b0; m_done[d] = 1'b1; m_t[d] = -1;
            end
         end
      end
   end

   // Per-cycle comparison against the model
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("cut_in%0d", d), 32'(cut_in_w[d]), 32'(m_cut[d]));
            chk($sformatf("sig%0d", d),    32'(sig_w[d]),    32'(m_sig[d]));
            chk($sformatf("busy%0d", d),   32'(busy_w[d]),   32'(m_busy[d]));
            chk($sformatf("tmode%0d", d),  32'(tmode_w[d]),  32'(m_busy[d]));
            chk($sformatf("done%0d", d),   32'(done_w[d]),   32'(m_done[d]));
            chk($sformatf("pass%0d", d),   32'(pass_w[d]),   32'(m_pass[d]));
         end
      end
   end

   task automatic wait_done0(input int max, output int n);
      n = 0;
      while (!done_w[0] && n < max) begin
         @(negedge clk);
         n++;
      end
      chk("wait_done0", 32'(done_w[0]), 32'd1);
   endtask

   task automatic kick();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      logic [2:0] lfsr_exp [8];
      logic [7:0] misr_exp [3];
      int n;
      lfsr_exp = '{3'd1, 3'd2, 3'd5, 3'd3, 3'd7, 3'd6, 3'd4, 3'd1};
      misr_exp = '{8'h01, 8'h03, 8'h07};
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; golden = 8'h00; sel = 0;
      repeat (2) @(negedge clk);
      chk("rst_cut_in", 32'(cut_in_w[0]), 32'd0);
      chk("rst_sig",    32'(sig_w[0]),    32'd0);
      chk("rst_busy",   32'(busy_w[0]),   32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // count mode, CUT tied low
      mode = 1'b1; sel = 0; golden = 8'h00;
      kick();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("cnt_pat0", 32'(cut_in_w[0]), 32'(k));
         if (k < 3) chk("cnt_pat1", 32'(cut_in_w[1]), 32'(k));
      end
      @(negedge clk);
      chk("cnt_done_e9", 32'(done_w[0]), 32'd0);
      @(negedge clk);
      chk("cnt_done_e10", 32'(done_w[0]), 32'd1);
      chk("cnt_sig",      32'(sig_w[0]),  32'h00);
      chk("cnt_pass",     32'(pass_w[0]), 32'd1);

      // LFSR mode; dut1 has SEED=000
      mode = 1'b0; sel = 2; golden = 8'h5A;
      kick();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("lfsr_pat0", 32'(cut_in_w[0]), 32'(lfsr_exp[k]));
         if (k < 3) chk("lfsr_pat1", 32'(cut_in_w[1]), 32'(lfsr_exp[k]));
      end
      wait_done0(5, n);

      // MISR arithmetic on dut1 (NPAT=3, CUT tied 001)
      for (int g = 0; g < 2; g++) begin
         sel = 1; golden = (g == 0) ? 8'h07 : 8'h06;
         kick();
         @(negedge clk);
         chk("misr_seed", 32'(sig_w[1]), 32'h00);
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("misr_sig", 32'(sig_w[1]), 32'(misr_exp[k]));
         end
         @(negedge clk);
         chk("misr_done", 32'(done_w[1]), 32'd1);
         chk("misr_pass", 32'(pass_w[1]), (g == 0) ? 32'd1 : 32'd0);
         wait_done0(8, n);
      end

      // abort together with start on the third RUN edge
      mode = 1'b1; sel = 2;
      kick();
      repeat (3) @(negedge clk);
      abort = 1'b1; start = 1'b1;
      @(negedge clk);
      abort = 1'b0; start = 1'b0;
      chk("abort_busy",  32'(busy_w[0]),   32'd0);
      chk("abort_tmode", 32'(tmode_w[0]),  32'd0);
      chk("abort_cut",   32'(cut_in_w[0]), 32'd0);
      chk("abort_sig",   32'(sig_w[0]),    32'd0);
      repeat (12) @(negedge clk);
      chk("abort_nodone", 32'(done_w[0]), 32'd0);

      // asynchronous reset mid-run, then a clean run
      mode = 1'b0; sel = 2;
      kick();
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy_w[0]),   32'd0);
      chk("arst_cut",  32'(cut_in_w[0]), 32'd0);
      chk("arst_sig",  32'(sig_w[0]),    32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mode = 1'b1; sel = 0; golden = 8'h00;
      kick();
      wait_done0(12, n);
      chk("arst_pass", 32'(pass_w[0]), 32'd1);

      // restart from DONE; start pulses during RUN are ignored
      sel = 2; golden = 8'h33;
      kick();
      chk("rs_done", 32'(done_w[0]), 32'd0);
      chk("rs_pass", 32'(pass_w[0]), 32'd0);
      chk("rs_busy", 32'(busy_w[0]), 32'd1);
      repeat (2) @(negedge clk);
      kick();
      wait_done0(20, n);
      chk("rs_latency", 32'(n), 32'd7);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/x3mult_bist_ctrl.md
# x3mult_bist_ctrl

Built-in self-test controller that sequences the `x3mult` combinational datapath as a circuit-under-test (CUT). It generates one 3-bit pattern per clock, compacts the 3-bit CUT response into a multiple-input signature register (MISR), and compares the final signature against a supplied golden value. It sits between the chip-level test controller and the CUT, which remains a separate instance; `test_mode` steers the CUT input mux.

## Interface
- `NPAT`, 8: patterns applied per run; legal range 1..255.
- `SEED`, 3'b001: initial LFSR pattern; a value of 0 is forced to 3'b001.
- `SIG_W`, 8: MISR width.
- `MISR_POLY`, 8'h1D: MISR feedback taps.
- `MISR_SEED`, 8'h00: MISR value loaded at run start.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE or DONE.
- `abort`  in  1  synchronous abort; highest priority.
- `mode`  in  1  0 = LFSR patterns, 1 = binary count (exhaustive); sampled at `start`.
- `golden_sig`  in  SIG_W  expected signature; sampled in COMP.
- `cut_out`  in  3  CUT response (combinational from `cut_in`).
- `cut_in`  out  3  registered pattern to CUT.
- `test_mode`  out  1  selects BIST pattern at the CUT input mux; equals `busy`.
- `busy`  out  1  high in INIT, RUN, COMP.
- `done`  out  1  high while in DONE.
- `pass`  out  1  compare result; valid while `done`=1.
- `signature`  out  SIG_W  current MISR contents.

## Operation
- Reset: state IDLE; `cut_in`=0, MISR=0, count=0, `busy`=`test_mode`=`done`=`pass`=0.
- States: IDLE, INIT, RUN, COMP, DONE.
- IDLE --start--> INIT; DONE --start--> INIT (clears `done` and `pass`). `start` is ignored in INIT, RUN, and COMP.
- INIT (1 cycle): latch `mode`; `cut_in` = SEED (LFSR mode) or 3'b000 (count mode); MISR = MISR_SEED; count = 0; go to RUN.
- RUN: each edge, MISR <= next(MISR, `cut_out`); `cut_in` advances; count++. When count == NPAT-1, go to COMP.
- LFSR step: next = {p[1:0], p[2]^p[1]}; period 7 (001→010→101→011→111→110→100→001). Never reaches 000.
- Count step: p+1 mod 8, wrapping 111→000.
- MISR step (Galois): next = {m[SIG_W-2:0],0} ^ (m[SIG_W-1] ? MISR_POLY : 0) ^ zero-extend(`cut_out`). `cut_out` bits XOR into MISR bits [2:0].
- COMP (1 cycle): `pass` <= (MISR == `golden_sig`); go to DONE.
- DONE: hold `done`=1, `pass`, `signature`, and the last `cut_in`.
- Abort: when `abort`=1 in any state, the next edge goes to IDLE and applies reset values to all outputs. Abort wins over a simultaneous `start`.
- Asynchronous reset mid-run: immediately returns to reset values; no partial result is retained.

## Timing
- Edge e0 samples `start`. e1 executes INIT. Edges e2..e(NPAT+1) perform the NPAT captures. e(NPAT+2) executes COMP; `done`=1 after e(NPAT+2).
- Pattern k (k=0..NPAT-1) is driven on `cut_in` after e(k+1) and captured from `cut_out` at e(k+2). The CUT and mux path must settle within one cycle.
- `busy`/`test_mode` rise after e0 and fall after e(NPAT+2).
- Back-to-back: `start` held in DONE restarts at the next edge; `done` falls after that edge.

## Structure
- Package `bist_pkg`: state enum, LFSR tap constant, default MISR_POLY/MISR_SEED, count width (8).
- Sub-module `bist_misr` (params SIG_W, POLY, IN_W=3): load, shift-enable, signature output.
- FSM, pattern generator, counter, and compare stay in `x3mult_bist_ctrl`.

## Test plan
- Count pattern order: mode=1, NPAT=8, `cut_out` tied 0 → `cut_in` = 0,1,…,7 on consecutive cycles starting after e1; `done` after e10; `signature`=00.
- LFSR pattern order: mode=0, NPAT=7, SEED=001 → `cut_in` = 001,010,101,011,111,110,100; SEED=000 produces the same sequence.
- MISR arithmetic: `cut_out` tied 3'b001, MISR_SEED=00, `golden_sig`=07, NPAT=3 → `signature` 01,03,07; `pass`=1. Same run with `golden_sig`=06 → `pass`=0.
- Abort: `abort` pulsed at the 3rd RUN cycle, together with `start` → IDLE next edge; all outputs 0; no `done`.
- Async reset: `rst_n` low mid-RUN → outputs 0 immediately; after release, a new `start` completes normally.
- Restart: `start` in DONE → INIT next edge; `done` and `pass` cleared; `start` pulses during RUN have no effect.
